// File: rtl/code_to_num_if.sv
// Segment-code beat stream in, decoded 3-digit frame out; bin_out exists only with BIN_OUT_EN.
// slave = decoder side, master = producer/consumer side.
interface code_to_num_if;
  logic [7:0]  seg_code;
  logic        seg_valid;
  logic        seg_sof;
  logic        seg_ready;
  logic [11:0] num_bcd;
  logic        num_valid;
  logic        code_err;
`ifdef BIN_OUT_EN
  logic [9:0]  bin_out;
`endif

  modport slave (
    input  seg_code, seg_valid, seg_sof,
`ifdef BIN_OUT_EN
    output bin_out,
`endif
    output seg_ready, num_bcd, num_valid, code_err
  );

  modport master (
    output seg_code, seg_valid, seg_sof,
`ifdef BIN_OUT_EN
    input  bin_out,
`endif
    input  seg_ready, num_bcd, num_valid, code_err
  );
endinterface

// File: rtl/code_to_num.sv
// 7-segment frame (hundreds, tens, units) to BCD; optional BIN_OUT_EN adds a CONV stage and bin_out.
// num_valid 1 cycle after the units beat (2 with BIN_OUT_EN); seg_ready drops only in OUT/CONV, output never stalls.
module code_to_num #(
  parameter int DP_IGNORE = 0
) (
  input logic           clk,
  input logic           rst,
  code_to_num_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    DIG2,
    DIG1,
    DIG0,
    OUT
`ifdef BIN_OUT_EN
    , CONV
`endif
  } state_t;

  state_t     state;
  logic [3:0] d2;
  logic [3:0] d1;
  logic       err;
  logic [4:0] dec;
  logic [3:0] dec_nib;
  logic       dec_err;
  logic       accept;

  // Returns {illegal, nibble}; blank and illegal both map to nibble F.
  function automatic logic [4:0] decode(input logic [7:0] code);
    logic [7:0] c;
    c = code;
    if (DP_IGNORE != 0) c[0] = 1'b0;
    case (c)
      8'hfc:   decode = 5'h00;
      8'h60:   decode = 5'h01;
      8'hda:   decode = 5'h02;
      8'hf2:   decode = 5'h03;
      8'h66:   decode = 5'h04;
      8'hb6:   decode = 5'h05;
      8'hbe:   decode = 5'h06;
      8'he0:   decode = 5'h07;
      8'hfe:   decode = 5'h08;
      8'hf6:   decode = 5'h09;
      8'h00:   decode = 5'h0f;
      default: decode = 5'h1f;
    endcase
  endfunction

  assign dec     = decode(bus.seg_code);
  assign dec_nib = dec[3:0];
  assign dec_err = dec[4];
  assign accept  = bus.seg_valid && bus.seg_ready;

`ifdef BIN_OUT_EN
  logic [3:0] d0;

  function automatic logic [9:0] dig_val(input logic [3:0] d);
    dig_val = (d > 4'd9) ? 10'd0 : {6'd0, d};
  endfunction

  function automatic logic [9:0] to_bin(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    to_bin = dig_val(h) * 10'd100 + dig_val(t) * 10'd10 + dig_val(u);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      bus.seg_ready <= 1'b0;
      bus.num_valid <= 1'b0;
      bus.num_bcd   <= 12'h000;
      bus.code_err  <= 1'b0;
      d2            <= 4'h0;
      d1            <= 4'h0;
      err           <= 1'b0;
`ifdef BIN_OUT_EN
      d0            <= 4'h0;
      bus.bin_out   <= 10'd0;
`endif
    end else begin
      bus.num_valid <= 1'b0;
      case (state)
        IDLE, DIG2: begin
          bus.seg_ready <= 1'b1;
          if (accept && bus.seg_sof) begin
            d2    <= dec_nib;
            err   <= dec_err;
            state <= DIG1;
          end
        end
        DIG1: begin
          if (accept) begin
            if (bus.seg_sof) begin
              d2  <= dec_nib;
              err <= dec_err;
            end else begin
              d1    <= dec_nib;
              err   <= err | dec_err;
              state <= DIG0;
            end
          end
        end
        DIG0: begin
          if (accept) begin
            if (bus.seg_sof) begin
              d2    <= dec_nib;
              err   <= dec_err;
              state <= DIG1;
            end else begin
              bus.seg_ready <= 1'b0;
`ifdef BIN_OUT_EN
              d0    <= dec_nib;
              err   <= err | dec_err;
              state <= CONV;
`else
              bus.num_bcd   <= {d2, d1, dec_nib};
              bus.code_err  <= err | dec_err;
              bus.num_valid <= 1'b1;
              state         <= OUT;
`endif
            end
          end
        end
`ifdef BIN_OUT_EN
        CONV: begin
          bus.num_bcd   <= {d2, d1, d0};
          bus.code_err  <= err;
          bus.bin_out   <= to_bin(d2, d1, d0);
          bus.num_valid <= 1'b1;
          state         <= OUT;
        end
`endif
        OUT: begin
          bus.seg_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.seg_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_to_num.sv
// Directed bench for code_to_num: reset state, decode patterns, restart, mid-frame reset, back-to-back frames.
module tb_code_to_num;
  logic clk = 1'b0;
  logic rst;

  code_to_num_if bus();

  code_to_num #(.DP_IGNORE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef BIN_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          acc_cyc = 0;
  int          pulse_cyc[$];
  logic [11:0] pulse_bcd[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.num_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_bcd.push_back(bus.num_bcd);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] c, input logic s);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.seg_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("seg_ready_before_beat", 32'(bus.seg_ready), 32'd1);
    bus.seg_code  = c;
    bus.seg_sof   = s;
    bus.seg_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.seg_valid = 1'b0;
    bus.seg_sof   = 1'b0;
    acc_cyc       = cyc;
  endtask

  task automatic frame(input logic [7:0] c2, input logic [7:0] c1, input logic [7:0] c0);
    beat(c2, 1'b1);
    beat(c1, 1'b0);
    beat(c0, 1'b0);
  endtask

  task automatic expect_one(input string tag, input int base, input logic [11:0] bcd,
                            input logic err, input logic [9:0] bin);
    repeat (6) @(negedge clk);
    check({tag, "_pulses"}, 32'(pulse_cyc.size() - base), 32'd1);
    if (pulse_cyc.size() > base) begin
      check({tag, "_latency"}, 32'(pulse_cyc[base] - acc_cyc + 1), 32'(LAT));
      check({tag, "_bcd_at_pulse"}, 32'(pulse_bcd[base]), 32'(bcd));
    end
    check({tag, "_bcd_held"}, 32'(bus.num_bcd), 32'(bcd));
    check({tag, "_code_err"}, 32'(bus.code_err), 32'(err));
`ifdef BIN_OUT_EN
    check({tag, "_bin_out"}, 32'(bus.bin_out), 32'(bin));
`else
    if (bin > 10'd999) check({tag, "_bin_range"}, 32'(bin), 32'd999);
`endif
    check({tag, "_ready_after"}, 32'(bus.seg_ready), 32'd1);
  endtask

  initial begin
    int base;
    int first_acc;
    rst           = 1'b0;
    bus.seg_code  = 8'h00;
    bus.seg_sof   = 1'b0;
    bus.seg_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg_ready", 32'(bus.seg_ready), 32'd0);
    check("rst_num_valid", 32'(bus.num_valid), 32'd0);
    check("rst_num_bcd",   32'(bus.num_bcd),   32'h000);
    check("rst_code_err",  32'(bus.code_err),  32'd0);
`ifdef BIN_OUT_EN
    check("rst_bin_out",   32'(bus.bin_out),   32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(bus.seg_ready), 32'd1);

    base = pulse_cyc.size();
    frame(8'hfc, 8'h60, 8'hda);
    expect_one("f012", base, 12'h012, 1'b0, 10'd12);

    base = pulse_cyc.size();
    frame(8'hf6, 8'hf6, 8'hf6);
    expect_one("f999", base, 12'h999, 1'b0, 10'd999);

    base = pulse_cyc.size();
    frame(8'h00, 8'h00, 8'hbe);
    expect_one("blank6", base, 12'hff6, 1'b0, 10'd6);

    base = pulse_cyc.size();
    frame(8'h60, 8'h33, 8'hfc);
    expect_one("illegal_mid", base, 12'h1f0, 1'b1, 10'd100);

    // Decimal point set is illegal when DP_IGNORE=0
    base = pulse_cyc.size();
    frame(8'hfd, 8'h61, 8'hdb);
    expect_one("dp_set", base, 12'hfff, 1'b1, 10'd0);

    base = pulse_cyc.size();
    beat(8'hfc, 1'b1);
    beat(8'h60, 1'b0);
    frame(8'hda, 8'hb6, 8'h66);
    expect_one("restart", base, 12'h254, 1'b0, 10'd254);

    base = pulse_cyc.size();
    beat(8'h33, 1'b1);
    beat(8'h60, 1'b0);
    frame(8'hfc, 8'hfc, 8'hf6);
    expect_one("restart_clr_err", base, 12'h009, 1'b0, 10'd9);

    base = pulse_cyc.size();
    beat(8'h60, 1'b0);
    frame(8'hf2, 8'h66, 8'hb6);
    expect_one("idle_discard", base, 12'h345, 1'b0, 10'd345);

    // Reset in the middle of a frame
    base = pulse_cyc.size();
    beat(8'hfc, 1'b1);
    beat(8'h60, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_seg_ready", 32'(bus.seg_ready), 32'd0);
    check("midrst_num_bcd",   32'(bus.num_bcd),   32'h000);
    rst = 1'b1;
    frame(8'h60, 8'h60, 8'h60);
    expect_one("after_midrst", base, 12'h111, 1'b0, 10'd111);

    // Back-to-back frames
    base = pulse_cyc.size();
    frame(8'h60, 8'hda, 8'hf2);
    beat(8'h66, 1'b1);
    first_acc = acc_cyc;
    beat(8'hb6, 1'b0);
    beat(8'hbe, 1'b0);
    repeat (6) @(negedge clk);
    check("b2b_pulses", 32'(pulse_cyc.size() - base), 32'd2);
    if (pulse_cyc.size() >= base + 2) begin
      check("b2b_first_bcd",  32'(pulse_bcd[base]),     32'h123);
      check("b2b_second_bcd", 32'(pulse_bcd[base + 1]), 32'h456);
      check("b2b_gap",        32'(first_acc - pulse_cyc[base]), 32'd2);
    end
    check("b2b_bcd_held", 32'(bus.num_bcd), 32'h456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/code_to_num.md
CODE_TO_NUM -- requirements
Module: code_to_num

Interface
REQ-001 The block SHALL have one parameter, DP_IGNORE, default 0; when it is 1, bit 0 (decimal point) of seg_code is masked to 0 before decoding.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port seg_code, input, 8 bits: one digit's segment code, bit order a..g,dp from bit 7 to bit 0.
REQ-005 The block SHALL have port seg_valid, input, 1 bit: seg_code is presented this cycle.
REQ-006 The block SHALL have port seg_sof, input, 1 bit: start of frame, qualified by seg_valid; it marks the hundreds digit.
REQ-007 The block SHALL have port seg_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port num_bcd, output, 12 bits: decoded BCD, hundreds in [11:8], tens in [7:4], units in [3:0].
REQ-009 The block SHALL have port num_valid, output, 1 bit: single-cycle pulse marking a complete frame on num_bcd.
REQ-010 The block SHALL have port code_err, output, 1 bit: the last completed frame contained at least one illegal code.
REQ-011 The block SHALL have port bin_out, output, 10 bits: the binary value of the frame; this port is present only with BIN_OUT_EN.

Function
REQ-012 A beat SHALL be accepted on any cycle where seg_valid=1 and seg_ready=1.
REQ-013 Each accepted code SHALL decode as: fc=0, 60=1, da=2, f2=3, 66=4, b6=5, be=6, e0=7, fe=8, f6=9, 00=blank (nibble F).
REQ-014 Any other code SHALL decode to nibble F and set the frame's error flag.
REQ-015 The FSM SHALL have the states IDLE, DIG2, DIG1, DIG0, OUT, plus CONV when BIN_OUT_EN is defined.
REQ-016 IDLE SHALL drive seg_ready=1 and SHALL discard any beat with seg_sof=0.
REQ-017 A beat with seg_sof=1 in IDLE SHALL store the hundreds digit and move the FSM to DIG1.
REQ-018 In DIG1 and DIG0, a beat with seg_sof=0 SHALL store the tens or units digit respectively.
REQ-019 In DIG1 and DIG0, a beat with seg_sof=1 SHALL restart the frame: store the hundreds digit, clear the error flag, go to DIG1, and emit no output for the abandoned frame.
REQ-020 DIG2 SHALL be an alias of IDLE-with-frame-open and is used only when it simplifies the implementation; observable behaviour SHALL match REQ-016 to REQ-019.
REQ-021 Accepting the units beat SHALL move the FSM to OUT (to CONV with BIN_OUT_EN).
REQ-022 seg_ready SHALL be 0 in OUT and CONV.
REQ-023 In OUT, num_valid SHALL be 1 for exactly one cycle, num_bcd and code_err SHALL be updated, and the FSM SHALL return to IDLE.
REQ-024 Latency from the cycle the units beat is accepted to num_valid SHALL be 1 cycle without BIN_OUT_EN and 2 cycles with it.
REQ-025 num_bcd, code_err and bin_out SHALL hold their values until the next num_valid.
REQ-026 The output has no backpressure; num_valid SHALL not wait on any downstream signal.
REQ-027 Back-to-back frames SHALL be accepted: a new seg_sof beat may be accepted in the cycle immediately after OUT.

Reset
REQ-028 While rst=0 at a clock edge, the FSM SHALL go to IDLE and all of the following SHALL be 0: seg_ready, num_valid, code_err, bin_out.
REQ-029 While rst=0, num_bcd SHALL be 12'h000 and any partial frame SHALL be discarded.
REQ-030 seg_ready SHALL be 1 in the first cycle after rst returns high.

Configuration
REQ-031 With macro BIN_OUT_EN defined, the CONV stage SHALL compute bin_out = d2*100 + d1*10 + d0, with blank or illegal digits counted as 0 (range 0..999), and publish it alongside num_bcd.
REQ-032 Without BIN_OUT_EN, the bin_out port, the CONV state and the arithmetic SHALL be absent.

Verification
REQ-033 Stimulus fc(sof),60,da -> response num_bcd=12'h012, code_err=0, bin_out=12, num_valid 1 cycle after the third beat (2 cycles with BIN_OUT_EN).
REQ-034 Stimulus f6(sof),f6,f6 -> response num_bcd=12'h999, bin_out=999.
REQ-035 Stimulus 00(sof),00,be -> response num_bcd=12'hFF6, code_err=0, bin_out=6.
REQ-036 Stimulus 60(sof),33,fc -> response num_bcd=12'h1F0, code_err=1, bin_out=100.
REQ-037 Stimulus fc(sof),60, then da(sof),b6,66 -> response exactly one num_valid, with num_bcd=12'h254.
REQ-038 Stimulus fc(sof),60, then rst=0 for 1 cycle, then 60(sof),60,60 -> response exactly one num_valid, with num_bcd=12'h111 and code_err=0.
